// File: rtl/scb_pkg.sv
// Shared sizing and register index constants for the register-read scoreboard.
package scb_pkg;
  localparam int NREGS = 8;
  localparam int IDX_W = $clog2(NREGS);
  localparam int CNT_W = 2;

  localparam logic [IDX_W-1:0] EAX = IDX_W'(0);
  localparam logic [IDX_W-1:0] ECX = IDX_W'(1);

  function automatic logic [CNT_W-1:0] cnt_max();
    return '1;
  endfunction
endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback side bundle of the scoreboard; fwd1/fwd2 exist only with SCB_WB_BYPASS_EN.
interface reg_scoreboard_if;
  import scb_pkg::*;

  logic             flush;
  logic             issue_valid;
  logic [IDX_W-1:0] issue_src1;
  logic [IDX_W-1:0] issue_src2;
  logic             issue_src2_imm;
  logic             issue_we;
  logic [IDX_W-1:0] issue_dst;
  logic             wb_valid;
  logic [IDX_W-1:0] wb_idx;
  logic             stall;
  logic             issue_accept;
  logic [NREGS-1:0] busy_vec;
  logic             err_underflow;
`ifdef SCB_WB_BYPASS_EN
  logic             fwd1;
  logic             fwd2;
`endif

  modport master (
    output flush, issue_valid, issue_src1, issue_src2, issue_src2_imm,
           issue_we, issue_dst, wb_valid, wb_idx,
    input
`ifdef SCB_WB_BYPASS_EN
           fwd1, fwd2,
`endif
           stall, issue_accept, busy_vec, err_underflow
  );

  modport slave (
    input  flush, issue_valid, issue_src1, issue_src2, issue_src2_imm,
           issue_we, issue_dst, wb_valid, wb_idx,
    output
`ifdef SCB_WB_BYPASS_EN
           fwd1, fwd2,
`endif
           stall, issue_accept, busy_vec, err_underflow
  );
endinterface

// File: rtl/scb_counter.sv
// Saturating up/down pending-write counter; inc+dec together hold, clr wins over both.
module scb_counter #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero,
  output logic         o_max
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && !o_max) begin
      r_cnt <= r_cnt + W'(1);
    end else if (i_dec && !i_inc && !o_zero) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);
  assign o_max  = &r_cnt;
endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write tracker and zero-latency issue interlock for register read.
// Optional writeback bypass (fwd1/fwd2) is built when SCB_WB_BYPASS_EN is defined.
module reg_scoreboard
  import scb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  bus
);
  logic [CNT_W-1:0] w_cnt [NREGS];
  logic [NREGS-1:0] w_zero;
  logic [NREGS-1:0] w_max;
  logic [NREGS-1:0] w_inc;
  logic [NREGS-1:0] w_dec;
  logic             w_h1;
  logic             w_h2;
  logic             w_hfull;
  logic             w_stall;
  logic             w_accept;
  logic             w_byp1;
  logic             w_byp2;
  logic             r_err;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_cnt
    assign w_inc[gi] = w_accept & bus.issue_we & (bus.issue_dst == IDX_W'(gi));
    // dec is gated on a live count so a stray writeback cannot move the counter
    assign w_dec[gi] = bus.wb_valid & (bus.wb_idx == IDX_W'(gi)) & ~w_zero[gi];

    scb_counter #(.W(CNT_W)) u_cnt (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_clr  (bus.flush),
      .i_inc  (w_inc[gi]),
      .i_dec  (w_dec[gi]),
      .o_cnt  (w_cnt[gi]),
      .o_zero (w_zero[gi]),
      .o_max  (w_max[gi])
    );

    assign bus.busy_vec[gi] = |w_cnt[gi];
  end

`ifdef SCB_WB_BYPASS_EN
  // last outstanding write lands this cycle, so read can take wdata directly
  assign w_byp1   = bus.wb_valid & (bus.wb_idx == bus.issue_src1) &
                    (w_cnt[bus.issue_src1] == CNT_W'(1));
  assign w_byp2   = ~bus.issue_src2_imm & bus.wb_valid & (bus.wb_idx == bus.issue_src2) &
                    (w_cnt[bus.issue_src2] == CNT_W'(1));
  assign bus.fwd1 = w_byp1;
  assign bus.fwd2 = w_byp2;
`else
  assign w_byp1   = 1'b0;
  assign w_byp2   = 1'b0;
`endif

  assign w_h1     = ~w_zero[bus.issue_src1] & ~w_byp1;
  assign w_h2     = ~bus.issue_src2_imm & ~w_zero[bus.issue_src2] & ~w_byp2;
  assign w_hfull  = bus.issue_we & w_max[bus.issue_dst];
  assign w_stall  = bus.issue_valid & (w_h1 | w_h2 | w_hfull);
  assign w_accept = bus.issue_valid & ~w_stall;

  assign bus.stall        = w_stall;
  assign bus.issue_accept = w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (!bus.flush && bus.wb_valid && w_zero[bus.wb_idx]) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err_underflow = r_err;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard-queue bench for reg_scoreboard; bypass cases compile in with SCB_WB_BYPASS_EN.
module tb_reg_scoreboard;
  import scb_pkg::*;

`ifdef SCB_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct packed {
    logic       rst;
    logic       flush;
    logic       v;
    logic [2:0] s1;
    logic [2:0] s2;
    logic       imm;
    logic       we;
    logic [2:0] dst;
    logic       wbv;
    logic [2:0] wbi;
  } stim_t;

  typedef struct packed {
    logic       stall;
    logic       accept;
    logic [7:0] busy;
    logic       err;
  } obs_t;

  logic        clk;
  logic        rst;
  logic [31:0] wdata;
  logic [31:0] wdata_next;
  int          n_checks;
  int          n_errors;
  obs_t        sb_q[$];

  reg_scoreboard_if sif();

  reg_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t iss(logic [2:0] s1, logic [2:0] s2, logic imm, logic we, logic [2:0] dst);
    stim_t s;
    s = '0;
    s.v = 1'b1; s.s1 = s1; s.s2 = s2; s.imm = imm; s.we = we; s.dst = dst;
    return s;
  endfunction

  function automatic stim_t wbk(logic [2:0] idx);
    stim_t s;
    s = '0;
    s.wbv = 1'b1; s.wbi = idx;
    return s;
  endfunction

  function automatic stim_t both(stim_t a, stim_t b);
    return stim_t'(a | b);
  endfunction

  function automatic stim_t fl(stim_t a);
    stim_t s;
    s = a;
    s.flush = 1'b1;
    return s;
  endfunction

  function automatic stim_t rs(stim_t a);
    stim_t s;
    s = a;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic obs_t ob(logic st, logic ac, logic [7:0] b, logic e);
    obs_t o;
    o.stall = st; o.accept = ac; o.busy = b; o.err = e;
    return o;
  endfunction

  // drives one cycle of stimulus, records its expectation, returns at the sampling edge
  task automatic apply(input stim_t st, input obs_t ex);
    rst                = st.rst;
    sif.flush          = st.flush;
    sif.issue_valid    = st.v;
    sif.issue_src1     = st.s1;
    sif.issue_src2     = st.s2;
    sif.issue_src2_imm = st.imm;
    sif.issue_we       = st.we;
    sif.issue_dst      = st.dst;
    sif.wb_valid       = st.wbv;
    sif.wb_idx         = st.wbi;
    wdata              = wdata_next;
    sb_q.push_back(ex);
    @(negedge clk);
  endtask

`ifdef SCB_WB_BYPASS_EN
  logic [31:0] rf [NREGS];
  initial for (int i = 0; i < NREGS; i++) rf[i] = 32'h0;
  always @(posedge clk) if (sif.wb_valid) rf[sif.wb_idx] <= wdata;
`endif

  task automatic test_reset();
    stim_t st[$]; obs_t ex[$]; obs_t got; obs_t exp_o;
    st.push_back(rs(idle()));                 ex.push_back(ob(0, 0, 8'h00, 0));
    st.push_back(rs(iss(2, 3, 0, 1, EAX)));   ex.push_back(ob(0, 1, 8'h00, 0));
    st.push_back(idle());                     ex.push_back(ob(0, 0, 8'h00, 0));
    foreach (st[k]) begin
      apply(st[k], ex[k]);
      got = obs_t'({sif.stall, sif.issue_accept, sif.busy_vec, sif.err_underflow});
      exp_o = sb_q.pop_front();
      n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL reset[%0d]: got stall/acc/busy/err=%b expected %b", k, got, exp_o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    stim_t st[$]; obs_t ex[$]; obs_t got; obs_t exp_o;
    st.push_back(iss(2, 3, 0, 1, EAX));                  ex.push_back(ob(0, 1, 8'h01 & 8'h00, 0));
    st.push_back(idle());                                ex.push_back(ob(0, 0, 8'h01, 0));
    st.push_back(iss(EAX, 3, 1, 0, 0));                  ex.push_back(ob(1, 0, 8'h01, 0));
    st.push_back(both(iss(EAX, 3, 1, 0, 0), wbk(EAX)));  ex.push_back(ob(~BYP, BYP, 8'h01, 0));
    st.push_back(iss(EAX, 3, 1, 0, 0));                  ex.push_back(ob(0, 1, 8'h00, 0));
    foreach (st[k]) begin
      apply(st[k], ex[k]);
      got = obs_t'({sif.stall, sif.issue_accept, sif.busy_vec, sif.err_underflow});
      exp_o = sb_q.pop_front();
      n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL basic[%0d]: got stall/acc/busy/err=%b expected %b", k, got, exp_o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_imm();
    stim_t st[$]; obs_t ex[$]; obs_t got; obs_t exp_o;
    st.push_back(iss(2, 3, 0, 1, ECX));   ex.push_back(ob(0, 1, 8'h00, 0));
    st.push_back(iss(3, ECX, 1, 0, 0));   ex.push_back(ob(0, 1, 8'h02, 0));
    st.push_back(iss(3, ECX, 0, 0, 0));   ex.push_back(ob(1, 0, 8'h02, 0));
    st.push_back(wbk(ECX));               ex.push_back(ob(0, 0, 8'h02, 0));
    st.push_back(idle());                 ex.push_back(ob(0, 0, 8'h00, 0));
    foreach (st[k]) begin
      apply(st[k], ex[k]);
      got = obs_t'({sif.stall, sif.issue_accept, sif.busy_vec, sif.err_underflow});
      exp_o = sb_q.pop_front();
      n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL imm[%0d]: got stall/acc/busy/err=%b expected %b", k, got, exp_o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_self_dep();
    stim_t st[$]; obs_t ex[$]; obs_t got; obs_t exp_o;
    st.push_back(iss(3, 3, 0, 1, 3));     ex.push_back(ob(0, 1, 8'h00, 0));
    st.push_back(iss(3, 3, 0, 1, 3));     ex.push_back(ob(1, 0, 8'h08, 0));
    st.push_back(wbk(3));                 ex.push_back(ob(0, 0, 8'h08, 0));
    st.push_back(idle());                 ex.push_back(ob(0, 0, 8'h00, 0));
    foreach (st[k]) begin
      apply(st[k], ex[k]);
      got = obs_t'({sif.stall, sif.issue_accept, sif.busy_vec, sif.err_underflow});
      exp_o = sb_q.pop_front();
      n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL self_dep[%0d]: got stall/acc/busy/err=%b expected %b", k, got, exp_o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full();
    stim_t st[$]; obs_t ex[$]; obs_t got; obs_t exp_o;
    stim_t w2;
    w2 = iss(3, 4, 0, 1, 2);
    st.push_back(w2);                  ex.push_back(ob(0, 1, 8'h00, 0));
    st.push_back(w2);                  ex.push_back(ob(0, 1, 8'h04, 0));
    st.push_back(w2);                  ex.push_back(ob(0, 1, 8'h04, 0));
    st.push_back(w2);                  ex.push_back(ob(1, 0, 8'h04, 0));
    st.push_back(both(w2, wbk(2)));    ex.push_back(ob(1, 0, 8'h04, 0));
    st.push_back(both(w2, wbk(2)));    ex.push_back(ob(0, 1, 8'h04, 0));
    st.push_back(w2);                  ex.push_back(ob(0, 1, 8'h04, 0));
    st.push_back(w2);                  ex.push_back(ob(1, 0, 8'h04, 0));
    for (int i = 0; i < 3; i++) begin
      st.push_back(wbk(2));            ex.push_back(ob(0, 0, 8'h04, 0));
    end
    st.push_back(idle());              ex.push_back(ob(0, 0, 8'h00, 0));
    foreach (st[k]) begin
      apply(st[k], ex[k]);
      got = obs_t'({sif.stall, sif.issue_accept, sif.busy_vec, sif.err_underflow});
      exp_o = sb_q.pop_front();
      n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL full[%0d]: got stall/acc/busy/err=%b expected %b", k, got, exp_o);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef SCB_WB_BYPASS_EN
  task automatic test_bypass();
    stim_t st[$]; obs_t ex[$]; logic [1:0] fx[$]; obs_t got; obs_t exp_o;
    logic [31:0] rd1;
    st.push_back(iss(2, 3, 0, 1, EAX));                    ex.push_back(ob(0, 1, 8'h00, 0)); fx.push_back(2'b00);
    st.push_back(both(iss(EAX, EAX, 1, 0, 0), wbk(EAX)));  ex.push_back(ob(0, 1, 8'h01, 0)); fx.push_back(2'b10);
    st.push_back(iss(2, 3, 0, 1, ECX));                    ex.push_back(ob(0, 1, 8'h00, 0)); fx.push_back(2'b00);
    st.push_back(both(iss(2, ECX, 0, 0, 0), wbk(ECX)));    ex.push_back(ob(0, 1, 8'h02, 0)); fx.push_back(2'b01);
    st.push_back(iss(2, 3, 0, 1, ECX));                    ex.push_back(ob(0, 1, 8'h00, 0)); fx.push_back(2'b00);
    st.push_back(iss(2, 3, 0, 1, ECX));                    ex.push_back(ob(0, 1, 8'h02, 0)); fx.push_back(2'b00);
    st.push_back(both(iss(2, ECX, 0, 0, 0), wbk(ECX)));    ex.push_back(ob(1, 0, 8'h02, 0)); fx.push_back(2'b00);
    st.push_back(wbk(ECX));                                ex.push_back(ob(0, 0, 8'h02, 0)); fx.push_back(2'b00);
    st.push_back(idle());                                  ex.push_back(ob(0, 0, 8'h00, 0)); fx.push_back(2'b00);
    foreach (st[k]) begin
      wdata_next = (k == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
      apply(st[k], ex[k]);
      got = obs_t'({sif.stall, sif.issue_accept, sif.busy_vec, sif.err_underflow});
      exp_o = sb_q.pop_front();
      n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL bypass[%0d]: got stall/acc/busy/err=%b expected %b", k, got, exp_o);
      end
      n_checks++;
      if ({sif.fwd1, sif.fwd2} !== fx[k]) begin
        n_errors++;
        $display("FAIL bypass_fwd[%0d]: got fwd1/fwd2=%b expected %b", k, {sif.fwd1, sif.fwd2}, fx[k]);
      end
      if (k == 1) begin
        rd1 = sif.fwd1 ? wdata : rf[sif.issue_src1];
        n_checks++;
        if (rd1 !== 32'hAAAA_AAAA) begin
          n_errors++;
          $display("FAIL bypass_data: got %h expected %h", rd1, 32'hAAAA_AAAA);
        end
      end
      @(posedge clk); #1;
    end
    wdata_next = 32'h5555_5555;
  endtask
`endif

  task automatic test_underflow_flush();
    stim_t st[$]; obs_t ex[$]; obs_t got; obs_t exp_o;
    st.push_back(wbk(5));                                     ex.push_back(ob(0, 0, 8'h00, 0));
    st.push_back(idle());                                     ex.push_back(ob(0, 0, 8'h00, 1));
    st.push_back(idle());                                     ex.push_back(ob(0, 0, 8'h00, 1));
    st.push_back(iss(6, 7, 0, 1, EAX));                       ex.push_back(ob(0, 1, 8'h00, 1));
    st.push_back(iss(6, 7, 0, 1, 2));                         ex.push_back(ob(0, 1, 8'h01, 1));
    st.push_back(fl(both(iss(EAX, 7, 0, 1, 4), wbk(EAX))));   ex.push_back(ob(~BYP, BYP, 8'h05, 1));
    st.push_back(idle());                                     ex.push_back(ob(0, 0, 8'h00, 1));
    st.push_back(fl(iss(6, 7, 0, 1, 4)));                     ex.push_back(ob(0, 1, 8'h00, 1));
    st.push_back(idle());                                     ex.push_back(ob(0, 0, 8'h00, 1));
    foreach (st[k]) begin
      apply(st[k], ex[k]);
      got = obs_t'({sif.stall, sif.issue_accept, sif.busy_vec, sif.err_underflow});
      exp_o = sb_q.pop_front();
      n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL underflow_flush[%0d]: got stall/acc/busy/err=%b expected %b", k, got, exp_o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    stim_t st[$]; obs_t ex[$]; obs_t got; obs_t exp_o;
    st.push_back(iss(0, 0, 0, 1, 6));     ex.push_back(ob(0, 1, 8'h00, 1));
    st.push_back(rs(idle()));             ex.push_back(ob(0, 0, 8'h40, 1));
    st.push_back(idle());                 ex.push_back(ob(0, 0, 8'h00, 0));
    st.push_back(wbk(6));                 ex.push_back(ob(0, 0, 8'h00, 0));
    st.push_back(idle());                 ex.push_back(ob(0, 0, 8'h00, 1));
    foreach (st[k]) begin
      apply(st[k], ex[k]);
      got = obs_t'({sif.stall, sif.issue_accept, sif.busy_vec, sif.err_underflow});
      exp_o = sb_q.pop_front();
      n_checks++;
      if (got !== exp_o) begin
        n_errors++;
        $display("FAIL reset_mid[%0d]: got stall/acc/busy/err=%b expected %b", k, got, exp_o);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    wdata_next = 32'h5555_5555;
    wdata      = 32'h5555_5555;
    rst        = 1'b1;
    sif.flush = 1'b0; sif.issue_valid = 1'b0; sif.issue_src1 = '0; sif.issue_src2 = '0;
    sif.issue_src2_imm = 1'b0; sif.issue_we = 1'b0; sif.issue_dst = '0;
    sif.wb_valid = 1'b0; sif.wb_idx = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_imm();
    test_self_dep();
    test_full();
`ifdef SCB_WB_BYPASS_EN
    test_bypass();
`endif
    test_underflow_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
